// File: rtl/tc_operand_feeder.sv
// Tensor-core operand feeder: buffers {A,B,C} beats and streams whole tiles to cores in round-robin order.
// Optional macro TC_FEED_PERF_CNT_EN adds saturating tile/stall counters (perf_tiles_o, perf_stalls_o).
module tc_operand_feeder #(
  parameter int NUM_CORES      = 4,
  parameter int A_W            = 512,
  parameter int B_W            = 256,
  parameter int C_W            = 512,
  parameter int BEATS_PER_TILE = 4,
  parameter int FIFO_DEPTH     = 2,
  localparam int PTR_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [A_W-1:0]       in_a_i,
  input  logic [B_W-1:0]       in_b_i,
  input  logic [C_W-1:0]       in_c_i,
  input  logic [NUM_CORES-1:0] core_idle_i,
  input  logic [NUM_CORES-1:0] core_fetch_i,
  output logic [NUM_CORES-1:0] start_o,
  output logic [NUM_CORES-1:0] fetch_done_o,
  output logic                 out_valid_o,
  output logic [PTR_W-1:0]     out_core_o,
  output logic [A_W-1:0]       a_data_out_o,
  output logic [B_W-1:0]       b_data_out_o,
  output logic [C_W-1:0]       c_data_out_o,
`ifdef TC_FEED_PERF_CNT_EN
  output logic                 busy_o,
  output logic [31:0]          perf_tiles_o,
  output logic [31:0]          perf_stalls_o
`else
  output logic                 busy_o
`endif
);

  // state      | meaning
  // IDLE       | wait for a buffered beat and the current core to be idle
  // START      | one-cycle start pulse to the current core
  // WAIT_FETCH | wait for the core to begin fetching
  // STREAM     | hand over one beat per cycle while core fetches and data is present
  // DONE       | one-cycle fetch_done pulse, advance to next core
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_FETCH, S_STREAM, S_DONE} state_t;

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int BC_W = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;

  logic [A_W-1:0] fa_q [FIFO_DEPTH];
  logic [B_W-1:0] fb_q [FIFO_DEPTH];
  logic [C_W-1:0] fc_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           full, empty, push, pop;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [BC_W-1:0]  beat_q, beat_d;

  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  assign empty      = (cnt_q == '0);
  assign in_ready_o = !full;
  assign push       = in_valid_i && !full;
  assign pop        = out_valid_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fa_q[wr_ptr_q] <= in_a_i;
      fb_q[wr_ptr_q] <= in_b_i;
      fc_q[wr_ptr_q] <= in_c_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      beat_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    beat_d       = beat_q;
    start_o      = '0;
    fetch_done_o = '0;
    out_valid_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && core_idle_i[ptr_q]) state_d = S_START;
      end
      S_START: begin
        start_o[ptr_q] = 1'b1;
        state_d        = S_WAIT_FETCH;
      end
      S_WAIT_FETCH: begin
        if (core_fetch_i[ptr_q]) state_d = S_STREAM;
      end
      S_STREAM: begin
        out_valid_o = core_fetch_i[ptr_q] && !empty;
        if (out_valid_o) begin
          if (beat_q == BC_W'(BEATS_PER_TILE - 1)) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        fetch_done_o[ptr_q] = 1'b1;
        ptr_d   = (ptr_q == PTR_W'(NUM_CORES - 1)) ? '0 : ptr_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head of the buffer is shown only while a beat is actually being handed over.
  assign out_core_o   = ptr_q;
  assign a_data_out_o = out_valid_o ? fa_q[rd_ptr_q] : '0;
  assign b_data_out_o = out_valid_o ? fb_q[rd_ptr_q] : '0;
  assign c_data_out_o = out_valid_o ? fc_q[rd_ptr_q] : '0;
  assign busy_o       = (state_q != S_IDLE) || !empty;

`ifdef TC_FEED_PERF_CNT_EN
  logic [31:0] perf_tiles_q, perf_stalls_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_tiles_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (state_q == S_DONE && perf_tiles_q != 32'hFFFF_FFFF)
        perf_tiles_q <= perf_tiles_q + 32'd1;
      if (state_q == S_STREAM && !out_valid_o && perf_stalls_q != 32'hFFFF_FFFF)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_tiles_o  = perf_tiles_q;
  assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tc_operand_feeder.sv
// Directed bench for tc_operand_feeder: reset, single tile, round robin, starvation, backpressure, busy core.
module tb_tc_operand_feeder;
  localparam int NUM_CORES = 4;
  localparam int A_W = 512;
  localparam int B_W = 256;
  localparam int C_W = 512;
  localparam int BPT = 4;
  localparam int FETCH_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [A_W-1:0]       in_a;
  logic [B_W-1:0]       in_b;
  logic [C_W-1:0]       in_c;
  logic [NUM_CORES-1:0] core_idle;
  logic [NUM_CORES-1:0] core_fetch;
  logic [NUM_CORES-1:0] start;
  logic [NUM_CORES-1:0] fetch_done;
  logic                 out_valid;
  logic [1:0]           out_core;
  logic [A_W-1:0]       a_out;
  logic [B_W-1:0]       b_out;
  logic [C_W-1:0]       c_out;
  logic                 busy;

  logic [NUM_CORES-1:0] fetch_en = '0;
  logic [NUM_CORES-1:0] fetch_block = '0;
  assign core_fetch = fetch_en & ~fetch_block;

  int n_checks = 0;
  int n_errors = 0;
  int push_id = 1;
  int exp_beat = 1;
  int bit_in_tile = 0;
  int n_start = 0;
  int n_done = 0;
  int bubbles = 0;
  logic prev_ov = 1'b0;
  logic [NUM_CORES-1:0] last_start = '0;

  tc_operand_feeder #(
    .NUM_CORES(NUM_CORES), .A_W(A_W), .B_W(B_W), .C_W(C_W),
    .BEATS_PER_TILE(BPT), .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_c_i(in_c),
    .core_idle_i(core_idle), .core_fetch_i(core_fetch),
    .start_o(start), .fetch_done_o(fetch_done), .out_valid_o(out_valid),
    .out_core_o(out_core), .a_data_out_o(a_out), .b_data_out_o(b_out),
    .c_data_out_o(c_out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Core model: fetch rises FETCH_LAT cycles after start, drops on fetch_done.
  initial begin
    logic [NUM_CORES-1:0] s, d;
    int lat [NUM_CORES];
    for (int i = 0; i < NUM_CORES; i++) lat[i] = 0;
    forever begin
      @(negedge clk);
      s = start;
      d = fetch_done;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (d[i] === 1'b1) fetch_en[i] = 1'b0;
        if (lat[i] > 0) begin
          lat[i]--;
          if (lat[i] == 0) fetch_en[i] = 1'b1;
        end
        if (s[i] === 1'b1) lat[i] = FETCH_LAT;
      end
    end
  end

  // Scoreboard: beats come out in push order, tiles land on cores in rotation.
  always @(negedge clk) begin
    if (!rst) begin
      if (start !== '0) begin
        check_eq("start_onehot", 64'(start), 64'(1) << (n_done % NUM_CORES));
        check_eq("start_vs_done", 64'(fetch_done), 64'd0);
        last_start = start;
        n_start++;
      end
      if (out_valid === 1'b1) begin
        check_eq("a_data", a_out[63:0], 64'(exp_beat));
        check_eq("b_data", b_out[63:0], 64'(exp_beat + 1000));
        check_eq("c_data", c_out[63:0], 64'(exp_beat + 2000));
        check_eq("out_core", 64'(out_core), 64'(n_done % NUM_CORES));
        exp_beat++;
        bit_in_tile++;
      end else begin
        check_eq("data_gated", 64'((|a_out) | (|b_out) | (|c_out)), 64'd0);
        if (bit_in_tile > 0 && bit_in_tile < BPT) bubbles++;
      end
      if (fetch_done !== '0) begin
        check_eq("fetch_done_onehot", 64'(fetch_done), 64'(1) << (n_done % NUM_CORES));
        check_eq("done_beats", 64'(bit_in_tile), 64'(BPT));
        check_eq("done_after_last", 64'(prev_ov), 64'd1);
        bit_in_tile = 0;
        n_done++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic push(input int n);
    for (int k = 0; k < n; k++) begin
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_a = A_W'(push_id);
      in_b = B_W'(push_id + 1000);
      in_c = C_W'(push_id + 2000);
      for (int t = 0; t < 500 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) check_eq("push_timeout", 64'd0, 64'd1);
      push_id++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (n_done >= n) break;
      @(posedge clk); #1;
    end
    check_eq("tiles_done", 64'(n_done), 64'(n));
  endtask

  task automatic wait_bit(input int n);
    for (int i = 0; i < 500; i++) begin
      if (bit_in_tile == n) break;
      @(posedge clk); #1;
    end
    check_eq("beat_progress", 64'(bit_in_tile), 64'(n));
  endtask

  initial begin
    int b0;
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = A_W'(77); in_b = B_W'(77); in_c = C_W'(77);
    core_idle = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_start", 64'(start), 64'd0);
    check_eq("rst_fetch_done", 64'(fetch_done), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", 64'((|a_out) | (|b_out) | (|c_out)), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Single tile on core 0
    push(4);
    wait_done(1);
    check_eq("single_starts", 64'(n_start), 64'd1);
    check_eq("single_beats", 64'(exp_beat), 64'd5);

    // Round robin: tiles 2..5 on cores 1,2,3,0
    push(16);
    wait_done(5);
    check_eq("rr_starts", 64'(n_start), 64'd5);
    check_eq("rr_last_start", 64'(last_start), 64'b0001);

    // Starvation: 5 bubbles between beat 2 and beat 3
    push(2);
    wait_bit(2);
    b0 = bubbles;
    repeat (4) begin @(posedge clk); #1; end
    push(2);
    wait_done(6);
    check_eq("starve_bubbles", 64'(bubbles - b0), 64'd5);

    // Backpressure: core 2 drops fetch for 3 cycles after beat 1
    fork
      push(4);
      begin
        wait_bit(1);
        fetch_block = 4'b0100;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("bp_hold", 64'(out_valid), 64'd0);
        end
        check_eq("bp_full", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        fetch_block = '0;
      end
    join
    wait_done(7);

    // Busy core: tiles 8,9 on cores 3,0, then core 1 not idle
    push(8);
    wait_done(9);
    core_idle = 4'b1101;
    fork
      push(4);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check_eq("busy_core_nostart", 64'(start), 64'd0);
        end
        check_eq("busy_core_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        core_idle = '1;
        @(negedge clk);
        check_eq("idle_rise_cycle", 64'(start), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("idle_rise_start", 64'(start), 64'b0010);
      end
    join
    wait_done(10);

    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("total_starts", 64'(n_start), 64'd10);
    check_eq("total_beats", 64'(exp_beat), 64'd41);
    check_eq("final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
